// File: rtl/debounce_pkg.sv
// Shared FSM state type and debounce-window helper for the key event arbiter.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CNT,
        PRESSED,
        RELEASE_CNT
    } key_fsm_e;

    // Debounce window in clock cycles: rounded up, never below one cycle.
    function automatic int calc_clk_cycles(input int clk_freq_mhz, input int glitch_time_ns);
        int cycles;
        cycles = (glitch_time_ns * clk_freq_mhz + 999) / 1000;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchronizer, stability counter and press/release FSM.
// press_stb_o is a single-cycle pulse on the cycle that completes a press.
module key_debounce_fsm
    import debounce_pkg::*;
#(
    parameter int CLK_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic pressed_o,
    output logic press_stb_o
);

    localparam int                CNT_W    = $clog2(CLK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_s;
    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_sample;

    // Synchronizer resets to 1 so a key held down through reset is seen as released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking so the second flop captures the first flop's pre-edge value.
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign key_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The current sample is the (cnt_q+1)-th consecutive one at the new level.
    assign last_sample = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_stb_o = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (!key_s) begin
                    if (last_sample) begin
                        state_d     = PRESSED;
                        cnt_d       = '0;
                        press_stb_o = 1'b1;
                    end else begin
                        state_d = PRESS_CNT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            PRESS_CNT: begin
                if (key_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (last_sample) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_stb_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    if (last_sample) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_CNT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE_CNT: begin
                if (!key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (last_sample) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressed_o = (state_q == PRESSED) || (state_q == RELEASE_CNT);

endmodule

// File: rtl/key_event_arbiter.sv
// Debounces KEYS raw key inputs and serialises press events through a
// round-robin arbiter with a valid/ready output and a sticky overflow flag.
module key_event_arbiter
    import debounce_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 150,
    parameter int GLITCH_TIME_NS = 10,
    parameter int KEYS           = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [KEYS-1:0]         key_i,
    output logic                    event_valid_o,
    output logic [$clog2(KEYS)-1:0] event_key_o,
    input  logic                    event_ready_i,
    output logic [KEYS-1:0]         key_state_o,
    output logic                    ovf_o,
    input  logic                    ovf_clr_i
);

    localparam int IDX_W      = $clog2(KEYS);
    localparam int CLK_CYCLES = calc_clk_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);

    logic [KEYS-1:0]  press_stb;
    logic [KEYS-1:0]  pending_q, pending_d;
    logic [KEYS-1:0]  grant_mask;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             grant_found;
    logic             load;
    logic             ovf_set;

    for (genvar g = 0; g < KEYS; g++) begin : g_key
        key_debounce_fsm #(
            .CLK_CYCLES (CLK_CYCLES)
        ) u_key (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .key_i       (key_i[g]),
            .pressed_o   (key_state_o[g]),
            .press_stb_o (press_stb[g])
        );
    end

    // Round-robin search starting one past the last granted key.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand_idx    = last_q;
        for (int i = 1; i <= KEYS; i++) begin
            cand_idx = IDX_W'((int'(last_q) + i) % KEYS);
            if (!grant_found && pending_q[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign load       = !event_valid_o || event_ready_i;
    assign grant_mask = (load && grant_found) ? (KEYS'(1) << grant_idx) : '0;

    // A press landing on the edge that grants the same key re-arms it.
    assign pending_d  = (pending_q & ~grant_mask) | press_stb;
    assign ovf_set    = |(press_stb & pending_q & ~grant_mask);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            last_q        <= IDX_W'(KEYS - 1);
            event_valid_o <= 1'b0;
            event_key_o   <= '0;
            ovf_o         <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (ovf_set) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
            if (load) begin
                event_valid_o <= grant_found;
                if (grant_found) begin
                    event_key_o <= grant_idx;
                    last_q      <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios plus random
// key/ready/clear traffic compared every cycle against a behavioural model.
module tb_key_event_arbiter;

    localparam int KEYS = 4;
    localparam int C    = 2;   // debounce window for 150 MHz / 10 ns

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [KEYS-1:0] key_i;
    logic            event_valid_o;
    logic [1:0]      event_key_o;
    logic            event_ready_i;
    logic [KEYS-1:0] key_state_o;
    logic            ovf_o;
    logic            ovf_clr_i;

    int n_checks = 0;
    int n_bad    = 0;

    key_event_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .key_i         (key_i),
        .event_valid_o (event_valid_o),
        .event_key_o   (event_key_o),
        .event_ready_i (event_ready_i),
        .key_state_o   (key_state_o),
        .ovf_o         (ovf_o),
        .ovf_clr_i     (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: raw samples delayed two edges, run-length debounce,
    // a pending set, a round-robin pointer and the registered event.
    logic [KEYS-1:0] raw_log[$];
    int              run[KEYS];
    bit              lvl[KEYS];
    bit              pend[KEYS];
    int              ptr;
    bit              m_valid;
    int              m_key;
    bit              m_ovf;
    int              ev_log[$];

    task automatic model_reset();
        raw_log.delete();
        for (int k = 0; k < KEYS; k++) begin
            run[k]  = 0;
            lvl[k]  = 1'b0;
            pend[k] = 1'b0;
        end
        ptr     = KEYS - 1;
        m_valid = 1'b0;
        m_key   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic [KEYS-1:0] seen;
        bit              press[KEYS];
        bit              load;
        bit              ovf_set;
        int              g;
        seen = (raw_log.size() >= 2) ? raw_log[raw_log.size() - 2] : '1;
        raw_log.push_back(key_i);
        if (raw_log.size() > 2) void'(raw_log.pop_front());
        for (int k = 0; k < KEYS; k++) begin
            press[k] = 1'b0;
            // raw 1 while pressed, or raw 0 while released, counts toward a change
            if (seen[k] == lvl[k]) begin
                run[k]++;
                if (run[k] == C) begin
                    lvl[k]   = !lvl[k];
                    run[k]   = 0;
                    press[k] = lvl[k];
                end
            end else begin
                run[k] = 0;
            end
        end
        load = !m_valid || event_ready_i;
        g    = -1;
        if (load) begin
            for (int i = 1; i <= KEYS; i++) begin
                int c;
                c = (ptr + i) % KEYS;
                if (g < 0 && pend[c]) g = c;
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_key = g;
                ptr   = g;
            end
        end
        ovf_set = 1'b0;
        for (int k = 0; k < KEYS; k++) begin
            if (press[k] && pend[k] && k != g) ovf_set = 1'b1;
        end
        for (int k = 0; k < KEYS; k++) begin
            if (k == g) pend[k] = 1'b0;
            if (press[k]) pend[k] = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (ovf_clr_i) m_ovf = 1'b0;
    endtask

    task automatic compare_model();
        logic [KEYS-1:0] exp_state;
        for (int k = 0; k < KEYS; k++) exp_state[k] = lvl[k];
        check("valid", int'(event_valid_o), int'(m_valid));
        check("key_state", int'(key_state_o), int'(exp_state));
        check("ovf", int'(ovf_o), int'(m_ovf));
        if (m_valid) check("ev_key", int'(event_key_o), m_key);
    endtask

    // Advance n clock cycles; inputs must already be set (we are at a negedge).
    task automatic step(input int n = 1);
        repeat (n) begin
            if (rst_ni && event_valid_o && event_ready_i) ev_log.push_back(int'(event_key_o));
            @(posedge clk_i);
            if (rst_ni) model_edge();
            @(negedge clk_i);
            compare_model();
        end
    endtask

    task automatic apply_reset();
        rst_ni    = 1'b0;
        key_i     = '1;
        ovf_clr_i = 1'b0;
        model_reset();
        #1;
        check("rst_valid", int'(event_valid_o), 0);
        check("rst_key", int'(event_key_o), 0);
        check("rst_state", int'(key_state_o), 0);
        check("rst_ovf", int'(ovf_o), 0);
        step(3);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b1;
        key_i         = '1;
        event_ready_i = 1'b1;
        ovf_clr_i     = 1'b0;
        model_reset();
        @(negedge clk_i);
        apply_reset();

        // Single press on key 1: state from edge 4, one-cycle event after edge 5.
        ev_log.delete();
        key_i = 4'b1101;
        step(3);
        check("t1_state_e3", int'(key_state_o[1]), 0);
        step(1);
        check("t1_state_e4", int'(key_state_o[1]), 1);
        check("t1_valid_e4", int'(event_valid_o), 0);
        step(1);
        check("t1_valid_e5", int'(event_valid_o), 1);
        check("t1_key_e5", int'(event_key_o), 1);
        step(1);
        check("t1_valid_e6", int'(event_valid_o), 0);
        key_i = '1;
        step(6);
        check("t1_events", ev_log.size(), 1);

        // One-cycle glitch on key 2 is rejected.
        ev_log.delete();
        key_i = 4'b1011;
        step(1);
        key_i = '1;
        step(8);
        check("t2_state", int'(key_state_o), 0);
        check("t2_events", ev_log.size(), 0);

        // Keys 0, 2, 3 together from a fresh pointer, then keys 0 and 1 after key 0.
        apply_reset();
        ev_log.delete();
        key_i = 4'b0010;
        step(8);
        check("t3_count", ev_log.size(), 3);
        if (ev_log.size() == 3) begin
            check("t3_ev0", ev_log[0], 0);
            check("t3_ev1", ev_log[1], 2);
            check("t3_ev2", ev_log[2], 3);
        end
        key_i = '1;
        step(8);
        key_i = 4'b1110;
        step(6);
        key_i = '1;
        step(6);
        ev_log.delete();
        key_i = 4'b1100;
        step(8);
        check("t3b_count", ev_log.size(), 2);
        if (ev_log.size() == 2) begin
            check("t3b_first", ev_log[0], 1);
            check("t3b_second", ev_log[1], 0);
        end
        key_i = '1;
        step(6);

        // Held event under back-pressure; press/release/press key 0 overflows.
        event_ready_i = 1'b0;
        key_i = 4'b0111;
        step(6);
        check("t4_valid", int'(event_valid_o), 1);
        check("t4_key", int'(event_key_o), 3);
        for (int c = 0; c < 16; c++) begin
            key_i = (c < 5 || c >= 10) ? 4'b1110 : 4'b1111;
            step(1);
            check("t4_hold_valid", int'(event_valid_o), 1);
            check("t4_hold_key", int'(event_key_o), 3);
        end
        check("t4_ovf", int'(ovf_o), 1);
        step(2);
        check("t4_ovf_sticky", int'(ovf_o), 1);
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        check("t4_ovf_clr", int'(ovf_o), 0);
        event_ready_i = 1'b1;
        key_i = '1;
        step(8);

        // Reset at edge 3 of a key-2 press: nothing emitted afterwards.
        key_i = 4'b1011;
        step(2);
        rst_ni = 1'b0;
        key_i  = '1;
        model_reset();
        #1;
        check("t5_rst_valid", int'(event_valid_o), 0);
        check("t5_rst_state", int'(key_state_o), 0);
        step(3);
        check("t5_rst_ovf", int'(ovf_o), 0);
        rst_ni = 1'b1;
        ev_log.delete();
        step(10);
        check("t5_events", ev_log.size(), 0);
        check("t5_valid", int'(event_valid_o), 0);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < KEYS; k++) begin
                if ($urandom_range(0, 5) == 0) key_i[k] = ~key_i[k];
            end
            event_ready_i = ($urandom_range(0, 3) != 0);
            ovf_clr_i     = ($urandom_range(0, 15) == 0);
            if (cyc == 1500) apply_reset();
            step(1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
